// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared types and constants for the 5-stage pipeline hazard controller:
//   pipe_ctrl_state_e : sequencer states (RUN, MEM_WAIT, FAULT)
//   pipe_ctrl_t       : the nine enable/flush signals driven into the datapath
//   NOP_INSTR         : encoding loaded into IF/ID on flush (addi x0,x0,0)
//   TMR_W             : width of the memory-wait counter (MEM_TIMEOUT <= 255)
// Helper functions return the canonical control patterns.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } pipe_ctrl_state_e;

   typedef struct packed {
      logic pc_write;
      logic pc_src_branch;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_flush;
      logic ex_mem_write;
      logic ex_mem_flush;
      logic mem_wb_bubble;
   } pipe_ctrl_t;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;
   localparam int          TMR_W     = 8;

   // Free-running pipeline: every register advances, nothing flushed.
   function automatic pipe_ctrl_t ctrl_run();
      pipe_ctrl_t c;
      c               = '0;
      c.pc_write      = 1'b1;
      c.if_id_write   = 1'b1;
      c.id_ex_write   = 1'b1;
      c.ex_mem_write  = 1'b1;
      return c;
   endfunction

   // Held in reset: nothing written, every stage presents a bubble.
   function automatic pipe_ctrl_t ctrl_reset();
      pipe_ctrl_t c;
      c               = '0;
      c.if_id_flush   = 1'b1;
      c.id_ex_flush   = 1'b1;
      c.ex_mem_flush  = 1'b1;
      c.mem_wb_bubble = 1'b1;
      return c;
   endfunction

   // Whole pipeline frozen behind MEM; WB receives a bubble each cycle.
   function automatic pipe_ctrl_t ctrl_freeze();
      pipe_ctrl_t c;
      c               = '0;
      c.mem_wb_bubble = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive frozen memory-wait cycles and flags when the count has
// reached MEM_TIMEOUT.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_clr      : synchronous clear (has priority over i_en)
//   i_en       : increment this cycle
//   o_expired  : count equals MEM_TIMEOUT
// -----------------------------------------------------------------------------
module mem_wait_timer
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   logic [TMR_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == TMR_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush sequencer for the 5-stage RV32 pipeline. Resolves load-use
// hazards (1-cycle bubble), taken branches resolved in MEM (3-cycle flush) and
// multi-cycle data-memory accesses (full freeze, with timeout into FAULT).
// Optional performance counters are built only when PIPE_PERF_CNT_EN is
// defined; otherwise the counter ports read as zero.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   id_rs1, id_rs2, id_uses_rs2  : source registers of the ID instruction
//   ex_mem_read, ex_rd           : load indication and rd held in ID/EX
//   mem_branch_taken             : branch in MEM resolved taken
//   mem_access, dmem_ready       : MEM stage access and memory handshake
//   pc_write .. mem_wb_bubble    : enables/flushes for PC and pipe registers
//   mem_timeout                  : sticky fault flag (FAULT state)
//   stall_lu_cnt, stall_mem_cnt, flush_cnt : performance counters
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int          CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             mem_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             pc_src_branch,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             ex_mem_flush,
   output logic             mem_wb_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_lu_cnt,
   output logic [CNT_W-1:0] stall_mem_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   pipe_ctrl_state_e r_state;
   pipe_ctrl_state_e w_next;
   pipe_ctrl_t       w_ctrl;
   logic             w_load_use;
   logic             w_advance;
   logic             w_tmr_en;
   logic             w_tmr_clr;
   logic             w_tmr_expired;
   logic             w_lu_evt;
   logic             w_br_evt;
   logic             w_mem_evt;

   // x0 never creates a dependency, so a load into x0 cannot stall.
   assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_tmr_clr),
      .i_en      (w_tmr_en),
      .o_expired (w_tmr_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_ctrl    = ctrl_run();
      w_advance = 1'b0;
      w_tmr_en  = 1'b0;
      w_tmr_clr = 1'b0;
      w_lu_evt  = 1'b0;
      w_br_evt  = 1'b0;
      w_mem_evt = 1'b0;

      if (rst) begin
         w_ctrl = ctrl_reset();
         w_next = RUN;
      end else begin
         unique case (r_state)
            RUN: begin
               // Memory wait outranks branch and load-use (also covers the
               // illegal access+branch combination).
               if (mem_access && !dmem_ready) begin
                  w_ctrl    = ctrl_freeze();
                  w_next    = MEM_WAIT;
                  w_tmr_en  = 1'b1;
                  w_mem_evt = 1'b1;
               end else begin
                  w_advance = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (dmem_ready) begin
                  // Release cycle behaves exactly like RUN; hazards held
                  // stable during the freeze are evaluated now.
                  w_next    = RUN;
                  w_tmr_clr = 1'b1;
                  w_advance = 1'b1;
               end else if (w_tmr_expired) begin
                  w_ctrl    = ctrl_freeze();
                  w_next    = FAULT;
                  w_mem_evt = 1'b1;
               end else begin
                  w_ctrl    = ctrl_freeze();
                  w_tmr_en  = 1'b1;
                  w_mem_evt = 1'b1;
               end
            end
            FAULT: begin
               w_ctrl = ctrl_freeze();
            end
            default: begin
               w_ctrl = ctrl_freeze();
               w_next = RUN;
            end
         endcase

         if (w_advance) begin
            if (mem_branch_taken) begin
               // The load-use victim is flushed anyway, so no stall here.
               w_ctrl.pc_src_branch = 1'b1;
               w_ctrl.if_id_flush   = 1'b1;
               w_ctrl.id_ex_flush   = 1'b1;
               w_ctrl.ex_mem_flush  = 1'b1;
               w_br_evt             = 1'b1;
            end else if (w_load_use) begin
               w_ctrl.pc_write    = 1'b0;
               w_ctrl.if_id_write = 1'b0;
               w_ctrl.id_ex_flush = 1'b1;
               w_lu_evt           = 1'b1;
            end
         end
      end
   end

   assign pc_write      = w_ctrl.pc_write;
   assign pc_src_branch = w_ctrl.pc_src_branch;
   assign if_id_write   = w_ctrl.if_id_write;
   assign if_id_flush   = w_ctrl.if_id_flush;
   assign id_ex_write   = w_ctrl.id_ex_write;
   assign id_ex_flush   = w_ctrl.id_ex_flush;
   assign ex_mem_write  = w_ctrl.ex_mem_write;
   assign ex_mem_flush  = w_ctrl.ex_mem_flush;
   assign mem_wb_bubble = w_ctrl.mem_wb_bubble;
   assign mem_timeout   = (r_state == FAULT);

`ifdef PIPE_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_lu_cnt;
   logic [CNT_W-1:0] r_stall_mem_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_lu_cnt  <= '0;
         r_stall_mem_cnt <= '0;
         r_flush_cnt     <= '0;
      end else begin
         if (w_lu_evt)  r_stall_lu_cnt  <= sat_inc(r_stall_lu_cnt);
         if (w_mem_evt) r_stall_mem_cnt <= sat_inc(r_stall_mem_cnt);
         if (w_br_evt)  r_flush_cnt     <= sat_inc(r_flush_cnt);
      end
   end

   assign stall_lu_cnt  = r_stall_lu_cnt;
   assign stall_mem_cnt = r_stall_mem_cnt;
   assign flush_cnt     = r_flush_cnt;
`else
   logic w_unused;
   assign w_unused      = &{1'b0, w_lu_evt, w_br_evt, w_mem_evt};
   assign stall_lu_cnt  = '0;
   assign stall_mem_cnt = '0;
   assign flush_cnt     = '0;
`endif

endmodule
